// File: rtl/instr_loader.sv
// instr_loader: boot loader that writes a length-prefixed, little-endian byte stream into instruction memory.
// Define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before the core is released.
module instr_loader #(
   parameter int MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        im_we,
   output logic [31:0] im_addr,
   output logic [31:0] im_wd,
   output logic        core_reset,
   output logic        done,
   output logic        error,
   output logic [15:0] words_loaded
);

`ifdef INSTR_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, FLUSH, DONE, ERROR} state_t;
`else
   typedef enum logic [2:0] {LEN0, LEN1, DATA, FLUSH, DONE, ERROR} state_t;
`endif

   state_t      state;
   logic [15:0] len;
   logic [15:0] word_idx;
   logic [1:0]  byte_idx;
   logic [23:0] asm_buf;
   logic        accept;
   logic [15:0] len_full;
   logic        last_word;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   assign accept    = in_valid && in_ready;
   assign len_full  = {in_data, len[7:0]};
   assign last_word = (word_idx == len - 16'd1);

   always_comb begin
      in_ready = 1'b0;
      case (state)
         LEN0, LEN1, DATA: in_ready = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
         CSUM:             in_ready = 1'b1;
`endif
         default:          in_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= LEN0;
         len          <= 16'd0;
         word_idx     <= 16'd0;
         byte_idx     <= 2'd0;
         asm_buf      <= 24'd0;
         im_we        <= 1'b0;
         im_addr      <= 32'd0;
         im_wd        <= 32'd0;
         core_reset   <= 1'b1;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= 16'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
         csum         <= 8'd0;
`endif
      end else begin
         im_we <= 1'b0;
         if (im_we)
            words_loaded <= words_loaded + 16'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
         if (accept)
            csum <= csum ^ in_data;
`endif
         case (state)
            LEN0: begin
               if (accept) begin
                  len[7:0] <= in_data;
                  state    <= LEN1;
               end
            end
            LEN1: begin
               if (accept) begin
                  len[15:8] <= in_data;
                  if (len_full == 16'd0 || len_full > 16'(MEM_WORDS)) begin
                     state <= ERROR;
                     error <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            // The 4th byte goes straight to the output regs, so the assembly buffer is free next cycle.
            DATA: begin
               if (accept) begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: asm_buf[7:0]   <= in_data;
                     2'd1: asm_buf[15:8]  <= in_data;
                     2'd2: asm_buf[23:16] <= in_data;
                     default: begin
                        im_we    <= 1'b1;
                        im_addr  <= {14'd0, word_idx, 2'b00};
                        im_wd    <= {in_data, asm_buf};
                        word_idx <= word_idx + 16'd1;
                        if (last_word) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                           state <= CSUM;
`else
                           state <= FLUSH;
`endif
                        end
                     end
                  endcase
               end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            CSUM: begin
               if (accept) begin
                  if (in_data == csum) begin
                     state      <= DONE;
                     done       <= 1'b1;
                     core_reset <= 1'b0;
                  end else begin
                     state <= ERROR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            FLUSH: begin
               state      <= DONE;
               done       <= 1'b1;
               core_reset <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized self-checking bench for instr_loader against a frame-level reference model.
// Honours INSTR_LOADER_CHECKSUM_EN the same way the design does.
module tb_instr_loader;
   localparam int MEM_WORDS = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        im_we;
   logic [31:0] im_addr;
   logic [31:0] im_wd;
   logic        core_reset;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   int vectors = 0;
   int miscompares = 0;
   int pulse_viol = 0;
   logic prev_we = 1'b0;

   logic [7:0]  frame[$];
   logic [31:0] got_addr[$];
   logic [31:0] got_wd[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_wd[$];
   logic        exp_done;
   logic        exp_error;

   instr_loader #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .im_we(im_we), .im_addr(im_addr), .im_wd(im_wd), .core_reset(core_reset),
      .done(done), .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   // Records every memory write and flags any write-enable pulse wider than one cycle.
   always @(negedge clk) begin
      if (reset) begin
         got_addr.delete();
         got_wd.delete();
         prev_we = 1'b0;
      end else begin
         if (im_we) begin
            got_addr.push_back(im_addr);
            got_wd.push_back(im_wd);
         end
         if (im_we && prev_we)
            pulse_viol++;
         prev_we = im_we;
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic make_frame(input int n);
      logic [7:0] x;
      int nbytes;
      frame.delete();
      frame.push_back(8'(n));
      frame.push_back(8'(n >> 8));
      nbytes = (n >= 1 && n <= MEM_WORDS) ? 4 * n : 4;
      for (int k = 0; k < nbytes; k++)
         frame.push_back(8'($urandom));
      x = 8'h00;
      foreach (frame[k]) x ^= frame[k];
`ifdef INSTR_LOADER_CHECKSUM_EN
      frame.push_back(x);
`endif
   endtask

   // Reference model: derive expected writes and final status straight from the frame bytes.
   task automatic model();
      int n;
      logic [7:0] x;
      exp_addr.delete();
      exp_wd.delete();
      n = int'(frame[0]) + 256 * int'(frame[1]);
      exp_error = (n == 0 || n > MEM_WORDS);
      exp_done = 1'b0;
      if (!exp_error) begin
         for (int i = 0; i < n; i++) begin
            exp_addr.push_back(32'(4 * i));
            exp_wd.push_back({frame[2+4*i+3], frame[2+4*i+2], frame[2+4*i+1], frame[2+4*i]});
         end
         exp_done = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
         x = 8'h00;
         for (int k = 0; k < 2 + 4 * n; k++) x ^= frame[k];
         if (frame.size() <= 2 + 4 * n || frame[2+4*n] != x) begin
            exp_done = 1'b0;
            exp_error = 1'b1;
         end
`endif
      end
   endtask

   task automatic send_frame(input int max_gap, input int limit, output int sent);
      sent = 0;
      for (int k = 0; k < frame.size() && k < limit; k++) begin
         in_valid = 1'b0;
         repeat ($urandom_range(max_gap, 0)) @(negedge clk);
         if (!in_ready) break;
         in_valid = 1'b1;
         in_data = frame[k];
         @(negedge clk);
         sent++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (in_ready !== 1'b1 || im_we !== 1'b0 || core_reset !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl: ready/we/core_reset=%b%b%b expected 101", in_ready, im_we, core_reset);
      end
      vectors++;
      if (im_addr !== 32'd0 || im_wd !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_data: addr=%h wd=%h expected 0/0", im_addr, im_wd);
      end
      vectors++;
      if (done !== 1'b0 || error !== 1'b0 || words_loaded !== 16'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_status: done=%b error=%b words=%0d expected 0/0/0", done, error, words_loaded);
      end
   endtask

   task automatic test_basic(input int max_gap, input bit hold_valid);
      int sent;
      logic [31:0] ea[$];
      logic [31:0] ew[$];
      ea = '{32'h0, 32'h4};
      ew = '{32'h00500093, 32'h00A00113};
      do_reset();
      frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
`ifdef INSTR_LOADER_CHECKSUM_EN
      frame.push_back(8'h73);
`endif
      send_frame(max_gap, frame.size(), sent);
`ifdef INSTR_LOADER_CHECKSUM_EN
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL basic_done_timing: done=%b one cycle after checksum, expected 1", done);
      end
`else
      vectors++;
      if (im_we !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL basic_flush: we/done/ready=%b%b%b expected 100", im_we, done, in_ready);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b1 || core_reset !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL basic_done_timing: done=%b core_reset=%b expected 1/0", done, core_reset);
      end
`endif
      if (hold_valid) begin
         in_valid = 1'b1;
         in_data = 8'($urandom);
      end
      repeat (6) @(negedge clk);
      in_valid = 1'b0;
      vectors++;
      if (got_addr.size() !== 2) begin
         miscompares++;
         $display("[TB] FAIL basic_write_count: got %0d expected 2", got_addr.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            vectors++;
            if (got_addr[i] !== ea[i] || got_wd[i] !== ew[i]) begin
               miscompares++;
               $display("[TB] FAIL basic_write%0d: addr=%h wd=%h expected %h/%h", i, got_addr[i], got_wd[i], ea[i], ew[i]);
            end
         end
      end
      vectors++;
      if (done !== 1'b1 || core_reset !== 1'b0 || error !== 1'b0 || in_ready !== 1'b0 || words_loaded !== 16'd2) begin
         miscompares++;
         $display("[TB] FAIL basic_final: done=%b core_reset=%b error=%b ready=%b words=%0d expected 1/0/0/0/2",
                  done, core_reset, error, in_ready, words_loaded);
      end
      vectors++;
      if (pulse_viol !== 0) begin
         miscompares++;
         $display("[TB] FAIL basic_pulse_width: %0d wide pulses expected 0", pulse_viol);
      end
   endtask

   task automatic test_bad_length();
      int sent;
      int lens[2];
      lens = '{0, MEM_WORDS + 1};
      foreach (lens[j]) begin
         do_reset();
         make_frame(lens[j]);
         send_frame(0, frame.size(), sent);
         vectors++;
         if (sent !== 2 || error !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bad_len%0d_error: sent=%0d error=%b ready=%b expected 2/1/0", lens[j], sent, error, in_ready);
         end
         repeat (4) @(negedge clk);
         vectors++;
         if (got_addr.size() !== 0 || core_reset !== 1'b1 || done !== 1'b0 || words_loaded !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL bad_len%0d_final: writes=%0d core_reset=%b done=%b words=%0d expected 0/1/0/0",
                     lens[j], got_addr.size(), core_reset, done, words_loaded);
         end
      end
   endtask

   task automatic test_frames(input string name, input int n, input int max_gap, input bit corrupt);
      int sent;
      do_reset();
      make_frame(n);
      if (corrupt) frame[frame.size()-1] ^= 8'(1 << $urandom_range(7, 0));
      model();
      send_frame(max_gap, frame.size(), sent);
      repeat (4) @(negedge clk);
      vectors++;
      if (got_addr.size() !== exp_addr.size()) begin
         miscompares++;
         $display("[TB] FAIL %s_write_count: got %0d expected %0d", name, got_addr.size(), exp_addr.size());
      end else begin
         for (int i = 0; i < exp_addr.size(); i++) begin
            vectors++;
            if (got_addr[i] !== exp_addr[i] || got_wd[i] !== exp_wd[i]) begin
               miscompares++;
               $display("[TB] FAIL %s_write%0d: addr=%h wd=%h expected %h/%h", name, i, got_addr[i], got_wd[i], exp_addr[i], exp_wd[i]);
            end
         end
      end
      vectors++;
      if (done !== exp_done || error !== exp_error || core_reset !== !exp_done || words_loaded !== 16'(exp_addr.size())) begin
         miscompares++;
         $display("[TB] FAIL %s_status: done=%b error=%b core_reset=%b words=%0d expected %b/%b/%b/%0d",
                  name, done, error, core_reset, words_loaded, exp_done, exp_error, !exp_done, exp_addr.size());
      end
   endtask

   task automatic test_max_image();
      test_frames("max_image", MEM_WORDS, 0, 1'b0);
      vectors++;
      if (got_addr.size() == 0 || got_addr[got_addr.size()-1] !== 32'h0000_00FC) begin
         miscompares++;
         $display("[TB] FAIL max_last_addr: got %h expected 000000fc", got_addr.size() ? got_addr[got_addr.size()-1] : 32'hx);
      end
   endtask

   task automatic test_reset_mid_load();
      int sent;
      do_reset();
      make_frame(3);
      send_frame(0, 7, sent);
      vectors++;
      if (words_loaded !== 16'd1) begin
         miscompares++;
         $display("[TB] FAIL midload_pre: words=%0d expected 1", words_loaded);
      end
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if (im_we !== 1'b0 || words_loaded !== 16'd0 || core_reset !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midload_reset: we=%b words=%0d core_reset=%b ready=%b done=%b expected 0/0/1/1/0",
                  im_we, words_loaded, core_reset, in_ready, done);
      end
      reset = 1'b0;
      test_frames("midload_reload", 3, 2, 1'b0);
   endtask

   task automatic test_random_frames();
      int n;
      for (int r = 0; r < 8; r++) begin
         n = (r == 5) ? MEM_WORDS + 1 + $urandom_range(50, 0) : $urandom_range(12, 1);
`ifdef INSTR_LOADER_CHECKSUM_EN
         test_frames("random", n, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
`else
         test_frames("random", n, $urandom_range(3, 0), 1'b0);
`endif
      end
   endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
   task automatic test_checksum_mismatch();
      int sent;
      do_reset();
      frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h72};
      send_frame(0, frame.size(), sent);
      vectors++;
      if (error !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL csum_bad_timing: error=%b done=%b ready=%b expected 1/0/0", error, done, in_ready);
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (core_reset !== 1'b1 || words_loaded !== 16'd2 || got_addr.size() !== 2) begin
         miscompares++;
         $display("[TB] FAIL csum_bad_final: core_reset=%b words=%0d writes=%0d expected 1/2/2",
                  core_reset, words_loaded, got_addr.size());
      end
   endtask
`endif

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      test_reset();
      test_basic(0, 1'b0);
      test_bad_length();
      test_max_image();
      test_basic(3, 1'b1);
      test_reset_mid_load();
      test_random_frames();
`ifdef INSTR_LOADER_CHECKSUM_EN
      test_checksum_mismatch();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
